// File: rtl/uart_rx_os_pkg.sv
// uart_pkg: shared definitions for the uart_rx_os receive path.
//   - parity mode encodings (PAR_NONE/PAR_EVEN/PAR_ODD)
//   - receiver FSM state type
//   - default divider width and a short divider for simulation
//   - 3-input majority helper used by the mid-bit voter
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int WORD_SIZE         = 16;
    localparam int DEFAULT_DIV_WIDTH = WORD_SIZE;

    // Short bit period that keeps simulation runs brief.
    localparam int SIM_DIVIDE = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } rx_state_t;

    function automatic logic vote3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: valid/ready word channel out of the receiver.
//   rx_data        head-of-FIFO data word
//   rx_parity_err  head word parity mismatch
//   rx_frame_err   head word had a stop bit sampled low
//   rx_valid       FIFO not empty
//   rx_ready       consumer accepts head word when rx_valid & rx_ready
// master: receiver side; slave: consumer side.
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data, rx_parity_err, rx_frame_err, rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_parity_err, rx_frame_err, rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_os_fifo.sv
// uart_rx_fifo: synchronous show-ahead FIFO.
//   clk, rst    clock, synchronous active-high reset (flushes contents)
//   push, din   write request and word
//   pop         read request; dout advances to the next entry next cycle
//   dout        head entry, taken directly from the storage registers
//   full, empty occupancy flags
// Push while full is ignored unless a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      count;
    logic             push_ok, pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wp] <= din;
                wp      <= wp + 1'b1;
            end
            if (pop_ok) rp <= rp + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampled asynchronous serial receiver.
//   clk, rst   clock, synchronous active-high reset
//   rxd        asynchronous serial line, idle high
//   divide     clk cycles per bit (values below 4 behave as 4)
//   rx         valid/ready word channel (master side)
//   break_det  one-cycle pulse per break event
//   overrun    one-cycle pulse when a completed word is dropped (FIFO full)
//   active     receiver FSM not idle
// Each bit is the majority of three samples around mid-bit; a frame is
// completed at the vote point of its last stop bit so the next start edge
// is never missed.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PAR_NONE,
    parameter int STOP_BITS  = 1,
    parameter int DIV_WIDTH  = DEFAULT_DIV_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic [DIV_WIDTH-1:0] divide,
    uart_rx_os_if.master         rx,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 active
);
    rx_state_t state, next;

    logic                 rxd_m, rxd_s, rxd_d;
    logic [DIV_WIDTH-1:0] div, half, cnt;
    logic [3:0]           bitn;
    logic [DATA_BITS-1:0] shreg;
    logic                 smp0, smp1, vote;
    logic                 par_bit, par_err, frm_err;
    logic                 at_s0, at_s1, at_vote, at_end, last_stop, is_break;
    logic                 push, brk_c, pop, fifo_full, fifo_empty;
    logic [DATA_BITS+1:0] fifo_din, fifo_dout;

    assign div       = (divide < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : divide;
    assign half      = div >> 1;
    assign at_s0     = (cnt == half - 1'b1);
    assign at_s1     = (cnt == half);
    assign at_vote   = (cnt == half + 1'b1);
    assign at_end    = (cnt == div - 1'b1);
    assign vote      = vote3(smp0, smp1, rxd_s);
    assign last_stop = (bitn == 4'(STOP_BITS - 1));
    assign is_break  = (shreg == '0) && !vote && ((PARITY == PAR_NONE) || !par_bit);
    assign active    = (state != S_IDLE);

    // Current stop bit is not yet in frm_err at the vote point, so fold it in here.
    assign fifo_din  = {frm_err | ~vote, par_err, shreg};

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_d <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            rxd_d <= rxd_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next;
    end

    always_comb begin
        next  = state;
        push  = 1'b0;
        brk_c = 1'b0;
        case (state)
            S_IDLE:   if (!rxd_s && rxd_d) next = S_START;
            S_START: begin
                if (at_vote && vote) next = S_IDLE;
                else if (at_end)     next = S_DATA;
            end
            S_DATA:   if (at_end && bitn == 4'(DATA_BITS - 1))
                          next = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            S_PARITY: if (at_end) next = S_STOP;
            S_STOP:   if (at_vote && last_stop) begin
                          if (is_break) begin
                              brk_c = 1'b1;
                              next  = S_BREAK;
                          end else begin
                              push  = 1'b1;
                              next  = S_IDLE;
                          end
                      end
            S_BREAK:  if (rxd_s && at_end) next = S_IDLE;
            default:  next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            bitn      <= '0;
            shreg     <= '0;
            smp0      <= 1'b1;
            smp1      <= 1'b1;
            par_bit   <= 1'b0;
            par_err   <= 1'b0;
            frm_err   <= 1'b0;
            break_det <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            break_det <= brk_c;
            overrun   <= push & fifo_full & ~pop;

            // In BREAK the counter measures continuous high time only.
            if (state == S_IDLE || next != state || at_end || (state == S_BREAK && !rxd_s))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            if (next != state)
                bitn <= '0;
            else if (at_end && (state == S_DATA || state == S_STOP))
                bitn <= bitn + 1'b1;

            if (at_s0) smp0 <= rxd_s;
            if (at_s1) smp1 <= rxd_s;

            case (state)
                S_IDLE: begin
                    par_bit <= 1'b0;
                    par_err <= 1'b0;
                    frm_err <= 1'b0;
                end
                S_DATA:   if (at_vote) shreg <= {vote, shreg[DATA_BITS-1:1]};
                S_PARITY: if (at_vote) begin
                              par_bit <= vote;
                              par_err <= (PARITY == PAR_ODD) ? (vote == ^shreg) : (vote != ^shreg);
                          end
                S_STOP:   if (at_vote && !vote) frm_err <= 1'b1;
                default:  ;
            endcase
        end
    end

    assign pop = rx.rx_valid & rx.rx_ready;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rx.rx_data       = fifo_dout[DATA_BITS-1:0];
    assign rx.rx_parity_err = fifo_dout[DATA_BITS];
    assign rx.rx_frame_err  = fifo_dout[DATA_BITS+1];
    assign rx.rx_valid      = ~fifo_empty;
endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised asynchronous serial receiver: next-generation RX path for the FTDI-facing UART. It accepts 5–9 data bits, optional even/odd parity and 1 or 2 stop bits, and samples each bit at mid-bit with 3-sample majority voting behind a 2-flop synchroniser. Received words, with per-word error flags, are buffered in a small FIFO behind a valid/ready interface. Break and overrun events are reported as separate pulses.

## Interface
- DATA_BITS, 8, data bits per frame, 5..9, sent LSB first
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, 1 or 2
- DIV_WIDTH, 16, width of `divide`
- FIFO_DEPTH, 4, entries, power of 2, ≥2
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rxd  in  1  asynchronous serial line, idle high
- divide  in  DIV_WIDTH  clk cycles per bit; values <4 are treated as 4; changed only while `active`=0
- rx_data  out  DATA_BITS  head-of-FIFO data word
- rx_parity_err  out  1  head word had a parity mismatch (0 when PARITY=0)
- rx_frame_err  out  1  head word had a stop bit sampled low
- rx_valid  out  1  FIFO not empty
- rx_ready  in  1  consumer accepts head word when rx_valid & rx_ready
- break_det  out  1  one-cycle pulse per break event
- overrun  out  1  one-cycle pulse when a completed word is dropped because the FIFO is full
- active  out  1  FSM not in IDLE

## Operation
- Input path: `rxd` passes through 2 flops (both reset to 1) to give rxd_s. A third flop gives rxd_d for edge detection.
- Bit counter: cnt runs 0..div-1 per bit, where div = max(divide, 4), and half = div>>1. The bit value is the majority of rxd_s sampled at cnt = half-1, half and half+1, latched at cnt = half+1.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: on rxd_s=0 & rxd_d=1, go to START with cnt=0.
- START: if the voted value is 1, this is a false start. Return to IDLE with no flags set. Otherwise, at cnt = div-1, go to DATA.
- DATA: vote each bit and shift it in LSB first. After DATA_BITS bits, at cnt = div-1, go to PARITY if PARITY≠0, otherwise to STOP.
- PARITY: vote the bit and compare it to the XOR of the data bits. Even parity expects the XOR value; odd parity expects its inverse. A mismatch sets the word's parity_err.
- STOP: vote each stop bit. Any stop bit voted 0 sets frame_err.
- Completion is evaluated at the vote point of the last stop bit (not at the end of the bit), so the next start edge is never missed:
  - If data=0, parity (if present) voted 0, and the last stop bit voted 0: this is a break. Pulse break_det, push nothing, go to BREAK.
  - Otherwise push {frame_err, parity_err, data} into the FIFO and go to IDLE.
- BREAK: wait until rxd_s=1 for a full div cycles, then go to IDLE. Low time of any length produces only one break_det.
- FIFO push when full: drop the word and pulse overrun. FIFO contents are unchanged.
- Pop: occurs when rx_valid & rx_ready. Push and pop in the same cycle are both performed, including when the FIFO is full (the pop frees the slot, so there is no overrun).

## Timing
- Reset values: rx_data=0, rx_parity_err=0, rx_frame_err=0, rx_valid=0, break_det=0, overrun=0, active=0, FIFO empty, state IDLE.
- Reset mid-frame: the partial word is discarded and the FIFO is flushed. The next falling edge after reset starts a new frame.
- Synchroniser latency: 2 clk from `rxd` to rxd_s. The START state is entered 1 clk after the edge appears on rxd_s.
- Push to rx_valid: rx_valid rises the cycle after the push. rx_data and the error flags are registered FIFO head outputs, stable while rx_valid=1 and rx_ready=0.
- Pop: a pop in cycle T presents the next entry (or rx_valid=0) in cycle T+1.
- break_det and overrun are registered and high for exactly 1 clk.

## Structure
- Package uart_pkg:
  - parity encoding constants PAR_NONE, PAR_EVEN, PAR_ODD
  - FSM state enum
  - DEFAULT_DIV_WIDTH = WORD_SIZE
  - sim divide override constant
- Sub-module uart_rx_fifo: synchronous FIFO parametrised by WIDTH and DEPTH, with show-ahead registered head, full/empty flags, and simultaneous push/pop support. Width is DATA_BITS+2.

## Test plan
- Config 8N1, divide=8, rxd sends 0xA5 → one word with rx_data=0xA5 and both error flags 0. rx_valid rises 1 clk after the push at the last stop bit's vote point.
- Config 8E1, divide=16, rxd sends 0x3C with the parity bit set to 1 → rx_data=0x3C, rx_parity_err=1. With parity bit 0 → rx_parity_err=0.
- Config 7O2, divide=10, rxd sends 0x55 with the second stop bit low → rx_data=0x55, rx_frame_err=1, no break_det.
- Config 8N1, divide=8, rxd held low for 30 bit times then high → exactly one break_det pulse, no push; then 0x12 is received correctly.
- FIFO_DEPTH=4, rx_ready=0, send 0x01..0x05 → overrun pulses once on the 5th word. Raising rx_ready then pops 0x01..0x04 in order, after which rx_valid=0.
- Glitch: rxd low for 3 clk with divide=16 → false start, no word, no flags. Reset asserted mid-DATA → all outputs return to their reset values, then the next frame 0xC3 is received correctly.
